// File: rtl/mem_pkg.sv
// Shared encodings for the data memory pipeline: access sizes, FSM states
// and the byte-enable helper used by the load/store path.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size_e'(size))
      SZ_B:    m = 4'b0001 << lane;
      SZ_H:    m = 4'b0011 << {lane[1], 1'b0};
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Lane formatting: replicates store data onto every lane and extracts /
// extends load data from a 32-bit memory word.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wrepl,
  output logic [31:0] rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store replication; the byte mask later picks the enabled lanes.
  always_comb begin
    case (size_e'(size))
      SZ_B:    wrepl = {4{wdata[7:0]}};
      SZ_H:    wrepl = {2{wdata[15:0]}};
      SZ_W:    wrepl = wdata;
      default: wrepl = 32'h0000_0000;
    endcase
  end

  always_comb begin
    case (lane)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      2'd3:    byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = rword[31:16];
    end else begin
      half_s = rword[15:0];
    end
  end

  always_comb begin
    case (size_e'(size))
      SZ_B:    rdata = {{24{sgn & byte_s[7]}}, byte_s};
      SZ_H:    rdata = {{16{sgn & half_s[15]}}, half_s};
      SZ_W:    rdata = rword;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Word-organised data memory with byte/half/word access, sign extension,
// a 1- or 2-cycle response pipeline, store trace and a reset clear sweep.
module data_mem_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int RD_LAT    = 1,
  parameter int CLEAR_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        trc_valid,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_addr,
  output logic [31:0] trc_data
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  state_e        state_r;
  logic [AW-1:0] clr_idx_r;

  logic          accept_s;
  logic          err_s;
  logic          do_store_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rword_s;
  logic [31:0]   wrepl_s;
  logic [31:0]   ldata_s;
  logic [31:0]   merged_s;
  logic [3:0]    mask_s;

  logic          s1_valid_r;
  logic          s1_err_r;
  logic [31:0]   s1_rdata_r;
  logic          trc_valid_r;
  logic [31:0]   trc_pc_r;
  logic [31:0]   trc_addr_r;
  logic [31:0]   trc_data_r;

  assign req_ready  = (state_r == ST_RUN);
  assign accept_s   = req_valid & req_ready;
  assign idx_s      = req_addr[AW+1:2];
  assign rword_s    = mem_r[idx_s];
  assign mask_s     = byte_mask(req_size, req_addr[1:0]);
  assign do_store_s = accept_s & req_we & ~err_s;

  mem_lane_fmt u_fmt (
    .size  (req_size),
    .lane  (req_addr[1:0]),
    .sgn   (req_signed),
    .wdata (req_wdata),
    .rword (rword_s),
    .wrepl (wrepl_s),
    .rdata (ldata_s)
  );

  // Error decode: alignment per size, illegal size, and any address bit above the array.
  always_comb begin
    case (size_e'(req_size))
      SZ_B:    err_s = 1'b0;
      SZ_H:    err_s = req_addr[0];
      SZ_W:    err_s = |req_addr[1:0];
      default: err_s = 1'b1;
    endcase
    if (|req_addr[31:AW+2]) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  always_comb begin
    merged_s = rword_s;
    for (int i = 0; i < 4; i++) begin
      if (mask_s[i]) begin
        merged_s[8*i +: 8] = wrepl_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = rword_s[8*i +: 8];
      end
    end
  end

  // Memory array: the clear sweep and stores never coincide since ready is low in CLEAR.
  always_ff @(posedge clk) begin
    if (!reset && state_r == ST_CLEAR) begin
      mem_r[clr_idx_r] <= 32'h0000_0000;
    end else if (!reset && do_store_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  // Control FSM: sweep one word per cycle, then serve requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= (CLEAR_CYC != 0) ? ST_CLEAR : ST_RUN;
      clr_idx_r <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_idx_r <= clr_idx_r + AW'(1);
          if (&clr_idx_r) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_CLEAR;
      endcase
    end
  end

  // First response stage and store trace, both loaded at the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      s1_err_r    <= 1'b0;
      s1_rdata_r  <= 32'h0000_0000;
      trc_valid_r <= 1'b0;
      trc_pc_r    <= 32'h0000_0000;
      trc_addr_r  <= 32'h0000_0000;
      trc_data_r  <= 32'h0000_0000;
    end else begin
      s1_valid_r  <= accept_s;
      s1_err_r    <= accept_s & err_s;
      s1_rdata_r  <= (accept_s & ~req_we & ~err_s) ? ldata_s : 32'h0000_0000;
      trc_valid_r <= do_store_s;
      if (do_store_s) begin
        trc_pc_r   <= req_pc;
        trc_addr_r <= {req_addr[31:2], 2'b00};
        trc_data_r <= merged_s;
      end
    end
  end

  assign trc_valid = trc_valid_r;
  assign trc_pc    = trc_pc_r;
  assign trc_addr  = trc_addr_r;
  assign trc_data  = trc_data_r;

  if (RD_LAT == 2) begin : g_lat2
    logic        s2_valid_r;
    logic        s2_err_r;
    logic [31:0] s2_rdata_r;

    // Extra response stage for two-cycle latency.
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid_r <= 1'b0;
        s2_err_r   <= 1'b0;
        s2_rdata_r <= 32'h0000_0000;
      end else begin
        s2_valid_r <= s1_valid_r;
        s2_err_r   <= s1_err_r;
        s2_rdata_r <= s1_rdata_r;
      end
    end

    assign resp_valid = s2_valid_r;
    assign resp_err   = s2_err_r;
    assign resp_rdata = s2_rdata_r;
  end else begin : g_lat1
    assign resp_valid = s1_valid_r;
    assign resp_err   = s1_err_r;
    assign resp_rdata = s1_rdata_r;
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench: two instances (RD_LAT 1 and 2) driven in lockstep, checked against
// a byte-array reference model plus directed vector tables.
module tb_data_mem_pipe;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;

  logic        ready  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        rerr   [2];
  logic        tvalid [2];
  logic [31:0] tpc    [2];
  logic [31:0] taddr  [2];
  logic [31:0] tdata  [2];

  always #5 clk = ~clk;

  data_mem_pipe #(.DEPTH(DEPTH), .RD_LAT(1), .CLEAR_CYC(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[0]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(rvalid[0]), .resp_rdata(rdata[0]), .resp_err(rerr[0]),
    .trc_valid(tvalid[0]), .trc_pc(tpc[0]), .trc_addr(taddr[0]), .trc_data(tdata[0])
  );

  data_mem_pipe #(.DEPTH(DEPTH), .RD_LAT(2), .CLEAR_CYC(1)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[1]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(rvalid[1]), .resp_rdata(rdata[1]), .resp_err(rerr[1]),
    .trc_valid(tvalid[1]), .trc_pc(tpc[1]), .trc_addr(taddr[1]), .trc_data(tdata[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; logic err; logic [31:0] rdata; } rsp_t;
  typedef struct { int due; logic [31:0] pc; logic [31:0] addr; logic [31:0] data; } trc_t;

  logic [7:0] mb [DEPTH*4];
  rsp_t rq0[$];
  rsp_t rq1[$];
  trc_t tq[$];

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if ((a >> 2) >= 32'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  task automatic model_apply(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] pc, input int acc);
    logic        e;
    logic [31:0] v;
    logic [31:0] ones;
    int          nb;
    e    = model_err(sz, a);
    v    = 32'h0;
    ones = 32'hFFFF_FFFF;
    nb   = 1 << sz;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mb[int'(a) + k] = wd[8*k +: 8];
        tq.push_back('{acc, pc, a & 32'hFFFF_FFFC, model_word(a)});
      end else begin
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[int'(a) + k];
        if (sg && nb < 4 && v[8*nb-1]) v = v | (ones << (8*nb));
      end
    end
    rq0.push_back('{acc, e, v});
    rq1.push_back('{acc + 1, e, v});
  endtask

  // ---------------- per-cycle output monitor ----------------
  always @(negedge clk) begin
    logic        ev;
    logic        ee;
    logic [31:0] ed;
    trc_t        et;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        ev = 1'b0; ee = 1'b0; ed = 32'h0;
        if (d == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin
          ev = 1'b1; ee = rq0[0].err; ed = rq0[0].rdata; void'(rq0.pop_front());
        end
        if (d == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin
          ev = 1'b1; ee = rq1[0].err; ed = rq1[0].rdata; void'(rq1.pop_front());
        end
        chk1($sformatf("resp_valid[lat%0d]", d + 1), rvalid[d], ev);
        if (ev) begin
          chk1($sformatf("resp_err[lat%0d]", d + 1), rerr[d], ee);
          chk32($sformatf("resp_rdata[lat%0d]", d + 1), rdata[d], ed);
        end
      end
      ev = 1'b0;
      et = '{0, 32'h0, 32'h0, 32'h0};
      if (tq.size() > 0 && tq[0].due == cyc) begin
        ev = 1'b1; et = tq.pop_front();
      end
      for (int d = 0; d < 2; d++) begin
        chk1($sformatf("trc_valid[lat%0d]", d + 1), tvalid[d], ev);
        if (ev) begin
          chk32($sformatf("trc_pc[lat%0d]", d + 1), tpc[d], et.pc);
          chk32($sformatf("trc_addr[lat%0d]", d + 1), taddr[d], et.addr);
          chk32($sformatf("trc_data[lat%0d]", d + 1), tdata[d], et.data);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_pc = pc;
    chk1("req_ready[lat1]", ready[0], 1'b1);
    chk1("req_ready[lat2]", ready[1], 1'b1);
    @(posedge clk); #1;
    model_apply(we, sz, sg, a, wd, pc, cyc);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    rq0.delete(); rq1.delete(); tq.delete();
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk1("rst resp_valid", rvalid[d], 1'b0);
      chk1("rst resp_err", rerr[d], 1'b0);
      chk32("rst resp_rdata", rdata[d], 32'h0);
      chk1("rst trc_valid", tvalid[d], 1'b0);
      chk32("rst trc_pc", tpc[d], 32'h0);
      chk32("rst trc_addr", taddr[d], 32'h0);
      chk32("rst trc_data", tdata[d], 32'h0);
      chk1("rst req_ready", ready[d], 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_sweep();
    int cnt;
    cnt = 0;
    while (ready[0] !== 1'b1 && cnt < DEPTH + 16) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk32("sweep_len", 32'(cnt), 32'(DEPTH));
    chk1("sweep_done[lat2]", ready[1], 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_tv;
    logic [31:0] exp_td;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();
    wait_sweep();

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'h0, 1'b1, 32'h1122_3344};
    tbl[1]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 1'b0, 32'h0, 1'b1, 32'h1122_AA44};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFAA, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_00AA, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 1'b0, 32'h0, 1'b1, 32'h8001_0000};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFF_8001, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'h0000_8001, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_1234, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h8001_0000, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'(DEPTH*4), 32'h0, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 32'(DEPTH*4), 32'h5555_5555, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'(DEPTH*4-4), 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000_1122, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_0044, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0};

    for (int i = 0; i < 17; i++) begin
      issue(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, 32'h1000 + 32'(i*4));
      req_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("vec%0d valid[lat1]", i), rvalid[0], 1'b1);
      chk1($sformatf("vec%0d err[lat1]", i), rerr[0], tbl[i].exp_err);
      chk32($sformatf("vec%0d rdata[lat1]", i), rdata[0], tbl[i].exp_rdata);
      chk1($sformatf("vec%0d trc_valid", i), tvalid[0], tbl[i].exp_tv);
      if (tbl[i].exp_tv) chk32($sformatf("vec%0d trc_data", i), tdata[0], tbl[i].exp_td);
      @(negedge clk);
      chk1($sformatf("vec%0d valid[lat2]", i), rvalid[1], 1'b1);
      chk32($sformatf("vec%0d rdata[lat2]", i), rdata[1], tbl[i].exp_rdata);
      @(posedge clk); #1;
    end

    // Read-after-write, full word and partial-lane merge, back to back.
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h2000);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h2004);
    req_valid = 1'b0;
    @(negedge clk); chk32("raw_word[lat1]", rdata[0], 32'hDEAD_BEEF);
    @(negedge clk); chk32("raw_word[lat2]", rdata[1], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_005A, 32'h2008);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h200C);
    req_valid = 1'b0;
    @(negedge clk); chk32("raw_merge[lat1]", rdata[0], 32'hDEAD_5AEF);
    @(negedge clk); chk32("raw_merge[lat2]", rdata[1], 32'hDEAD_5AEF);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        r  = $urandom_range(0, 15);
        sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
        r  = $urandom_range(0, 9);
        if (r < 5)      a = 32'($urandom_range(0, 31));
        else if (r < 9) a = 32'($urandom_range(0, DEPTH*4-1));
        else if ($urandom_range(0, 1) == 1) a = 32'(DEPTH*4) + 32'($urandom_range(0, 15));
        else            a = $urandom | 32'h8000_0000;
        if ($urandom_range(0, 7) != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom);
      end
    end
    idle(4);

    // Fill memory, reset, reset again mid-sweep, then every word must read zero.
    for (int w = 0; w < DEPTH; w++) issue(1'b1, 2'b10, 1'b0, 32'(w*4), $urandom | 32'h1, 32'h3000);
    idle(3);
    do_reset();
    idle(DEPTH / 2);
    do_reset();
    wait_sweep();
    for (int w = 0; w < DEPTH; w++) issue(1'b0, 2'b10, 1'b0, 32'(w*4), 32'h0, 32'h4000);
    idle(4);

    // Three loads in flight when reset hits: nothing may come out afterwards.
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFE_F00D, 32'h5000);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h5004);
    issue(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'h5008);
    issue(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h500C);
    do_reset();
    wait_sweep();
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h6000);
    idle(4);

    chk32("rq0_drained", 32'(rq0.size()), 32'h0);
    chk32("rq1_drained", 32'(rq1.size()), 32'h0);
    chk32("tq_drained", 32'(tq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
